// File: rtl/output_mems_pkg.sv
// Shared types and constants for the result-side stream buffer.
package output_mems_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/output_mems_if.sv
// Result write port, completion strobe and AXI-Stream master bundle.
interface output_mems_if #(
    parameter int OUTW = 28,
    parameter int M    = 7,
    parameter int N    = 9
);
    localparam int C_ADDR_BITS = $clog2(M * N);

    logic                   C_wr_en;
    logic [C_ADDR_BITS-1:0] C_wr_addr;
    logic signed [OUTW-1:0] C_wr_data;
    logic                   compute_done;
    logic                   output_ready;
    logic [OUTW-1:0]        AXIS_TDATA;
    logic                   AXIS_TVALID;
    logic                   AXIS_TLAST;
    logic                   AXIS_TREADY;

    modport master (
        input  C_wr_en, C_wr_addr, C_wr_data, compute_done, AXIS_TREADY,
        output output_ready, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST
    );

    modport slave (
        output C_wr_en, C_wr_addr, C_wr_data, compute_done, AXIS_TREADY,
        input  output_ready, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST
    );
endinterface

// File: rtl/output_mems_memory.sv
// Single-port RAM with registered read (read-before-write on the same address).
module memory #(
    parameter int WIDTH = 28,
    parameter int SIZE  = 63
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [$clog2(SIZE)-1:0] i_addr,
    input  logic [WIDTH-1:0]        i_wdata,
    output logic [WIDTH-1:0]        o_rdata
);
    logic [WIDTH-1:0] r_mem [SIZE];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/output_mems.sv
// Buffers the result matrix C and streams it row-major over AXI-Stream,
// using a 2-entry skid FIFO behind the 1-cycle-latency RAM.
module output_mems
    import output_mems_pkg::*;
#(
    parameter int OUTW = 28,
    parameter int M    = 7,
    parameter int N    = 9
) (
    input  logic          clk,
    input  logic          reset,
    output_mems_if.master bus
);
    localparam int MN          = M * N;
    localparam int C_ADDR_BITS = $clog2(MN);
    localparam int CNT_BITS    = $clog2(MN + 1);
    localparam logic [CNT_BITS-1:0] CNT_END  = CNT_BITS'(MN);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_BITS-1:0]    r_rd_addr;
    logic [CNT_BITS-1:0]    r_beat_cnt;
    logic                   r_in_flight;
    logic [1:0]             r_count;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [OUTW-1:0]        r_fifo [FIFO_DEPTH];

    logic                   w_valid;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic                   w_last_beat;
    logic [2:0]             w_occ;
    logic                   w_ram_we;
    logic [C_ADDR_BITS-1:0] w_ram_addr;
    logic [OUTW-1:0]        w_ram_rdata;

    memory #(
        .WIDTH (OUTW),
        .SIZE  (MN)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (bus.C_wr_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Occupancy projection counts the read already in the RAM pipeline so the FIFO never overflows.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = (r_count != 2'd0);
        w_pop       = w_valid && bus.AXIS_TREADY;
        w_push      = r_in_flight;
        w_last_beat = w_pop && (r_beat_cnt == CNT_LAST);
        w_occ       = {1'b0, r_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
        w_issue     = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = bus.C_wr_addr;
        case (r_state)
            IDLE: begin
                w_ram_we = bus.C_wr_en;
                if (bus.compute_done) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_ram_addr = r_rd_addr[C_ADDR_BITS-1:0];
                w_issue    = (r_rd_addr < CNT_END) && (w_occ < 3'(FIFO_DEPTH));
                if (w_last_beat) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_last_beat) begin
            r_rd_addr   <= '0;
            r_beat_cnt  <= '0;
            r_in_flight <= 1'b0;
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            r_count     <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_issue) r_rd_addr  <= r_rd_addr + 1'b1;
            if (w_pop)   r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_pop)   r_rd_ptr   <= ~r_rd_ptr;
            if (w_push)  r_wr_ptr   <= ~r_wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= w_ram_rdata;
        end
    end

    assign bus.output_ready = (r_state == IDLE);
    assign bus.AXIS_TVALID  = w_valid;
    assign bus.AXIS_TDATA   = r_fifo[r_rd_ptr];
    assign bus.AXIS_TLAST   = w_valid && (r_beat_cnt == CNT_LAST);

endmodule
